// File: rtl/cache_tag_ctrl.sv
// cache_tag_ctrl: tag lookup, LRU update and miss/fill sequencing for a
// 2-way, 64-set cache. Address split is tag[15:10], index[9:4], and blocks
// are 16 bytes. The module drives the select and write strobes of the two
// metadata way arrays and reads back their {LRU,V,tag} entries.
module cache_tag_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    input  logic [15:0]      req_addr_i,
    output logic             req_ready_o,
    output logic             resp_valid_o,
    output logic             resp_way_o,
    output logic             resp_miss_o,
    output logic             fill_req_o,
    output logic [15:0]      fill_addr_o,
    input  logic             fill_done_i,
    output logic [63:0]      set_enable_o,
    output logic [7:0]       way0_data_in_o,
    output logic [7:0]       way1_data_in_o,
    output logic             way0_wen_o,
    output logic             way1_wen_o,
    output logic             way0_lru_en_o,
    output logic             way1_lru_en_o,
    input  logic [7:0]       way0_data_out_i,
    input  logic [7:0]       way1_data_out_i,
    output logic [CNT_W-1:0] hit_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o
);

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_MISS, S_FILL} state_t;

    state_t             state_q, state_d;
    logic [15:0]        addr_q;
    logic [15:0]        fill_addr_q;
    logic               victim_q;
    logic               replay_q;
    logic [CNT_W-1:0]   hit_cnt_q, miss_cnt_q;

    logic [5:0]         tag;
    logic [5:0]         idx;
    logic               hit0, hit1, hit, hit_way, victim;

    assign tag = addr_q[15:10];
    assign idx = addr_q[9:4];

    // Way 0 wins when both ways report the tag.
    assign hit0    = way0_data_out_i[6] && (way0_data_out_i[5:0] == tag);
    assign hit1    = way1_data_out_i[6] && (way1_data_out_i[5:0] == tag);
    assign hit     = hit0 | hit1;
    assign hit_way = ~hit0;

    // Invalid ways are filled first; with both valid, take way 1 only when it alone is LRU.
    assign victim = way0_data_out_i[6] &
                    (~way1_data_out_i[6] | (way1_data_out_i[7] & ~way0_data_out_i[7]));

    // State register; reset drops any in-flight request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state: IDLE -> LOOKUP -> IDLE|MISS, MISS -> FILL -> LOOKUP replay.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req_valid_i) state_d = S_LOOKUP;
            S_LOOKUP: state_d = hit ? S_IDLE : S_MISS;
            S_MISS:   if (fill_done_i) state_d = S_FILL;
            S_FILL:   state_d = S_LOOKUP;
            default:  state_d = S_IDLE;
        endcase
    end

    // Request address, victim, fill address, replay flag and saturating counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q      <= '0;
            fill_addr_q <= '0;
            victim_q    <= 1'b0;
            replay_q    <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            if (state_q == S_IDLE && req_valid_i) begin
                addr_q   <= req_addr_i;
                replay_q <= 1'b0;
            end
            if (state_q == S_FILL) replay_q <= 1'b1;
            if (state_q == S_LOOKUP && !hit) begin
                victim_q    <= victim;
                fill_addr_q <= {addr_q[15:4], 4'b0000};
            end
            if (state_q == S_LOOKUP && !replay_q) begin
                if (hit && hit_cnt_q != '1)   hit_cnt_q  <= hit_cnt_q + 1'b1;
                if (!hit && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
            end
        end
    end

    // Outputs per state: array select, LRU/fill writes, handshakes.
    always_comb begin
        req_ready_o    = 1'b0;
        resp_valid_o   = 1'b0;
        resp_way_o     = 1'b0;
        resp_miss_o    = 1'b0;
        fill_req_o     = 1'b0;
        set_enable_o   = '0;
        way0_data_in_o = '0;
        way1_data_in_o = '0;
        way0_wen_o     = 1'b0;
        way1_wen_o     = 1'b0;
        way0_lru_en_o  = 1'b0;
        way1_lru_en_o  = 1'b0;
        case (state_q)
            S_IDLE: req_ready_o = 1'b1;
            S_LOOKUP: begin
                set_enable_o = 64'd1 << idx;
                if (hit) begin
                    resp_valid_o      = 1'b1;
                    resp_way_o        = hit_way;
                    way0_lru_en_o     = 1'b1;
                    way1_lru_en_o     = 1'b1;
                    way0_data_in_o[7] = hit_way;
                    way1_data_in_o[7] = ~hit_way;
                end else begin
                    resp_miss_o = ~replay_q;
                end
            end
            S_MISS: fill_req_o = 1'b1;
            S_FILL: begin
                set_enable_o = 64'd1 << idx;
                if (!victim_q) begin
                    way0_wen_o     = 1'b1;
                    way0_data_in_o = {2'b01, tag};
                    way1_lru_en_o  = 1'b1;
                    way1_data_in_o = 8'h80;
                end else begin
                    way1_wen_o     = 1'b1;
                    way1_data_in_o = {2'b01, tag};
                    way0_lru_en_o  = 1'b1;
                    way0_data_in_o = 8'h80;
                end
            end
            default: ;
        endcase
    end

    assign fill_addr_o = fill_addr_q;
    assign hit_cnt_o   = hit_cnt_q;
    assign miss_cnt_o  = miss_cnt_q;

endmodule
